// File: rtl/ts_merge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ts_merge_pkg
//  Description : Shared types and constants for the timestamp merger.
//                - ts_entry_t   : layout of one buffered entry {data, fp} at
//                                 the default payload/fingerprint widths
//                - C_OVF_CNT_W  : width of each per-port drop counter
//                - ovf_sat_inc  : saturating increment for drop counters
//                Optional feature macro: TS_MERGE_OVF_CNT_EN
//  Revision    : 1.0  initial release
// ============================================================================
package ts_merge_pkg;

   localparam int C_DATA_W_DEF = 96;
   localparam int C_FP_W_DEF   = 8;
   localparam int C_OVF_CNT_W  = 16;

   // Entry layout: data in the upper bits, fingerprint in the lower bits.
   // The FIFOs store this same concatenation at the configured widths.
   typedef struct packed {
      logic [C_DATA_W_DEF-1:0] data;
      logic [C_FP_W_DEF-1:0]   fp;
   } ts_entry_t;

   function automatic logic [C_OVF_CNT_W-1:0] ovf_sat_inc(
      input logic [C_OVF_CNT_W-1:0] cnt
   );
      return (&cnt) ? cnt : cnt + 1'b1;
   endfunction

endpackage : ts_merge_pkg
`default_nettype wire

// File: rtl/ts_merge_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ts_merge_fifo
//  Description : Per-port circular buffer for the timestamp merger.
//                A push is accepted when not full, or when full and popped
//                in the same cycle. Read data is the current head (show-ahead).
//  Ports       : clk, rst_n    - clock, asynchronous active-low reset
//                i_push        - write request (input strobe)
//                i_wdata       - entry to write
//                i_pop         - remove head entry
//                o_rdata       - head entry
//                o_empty/o_full- occupancy flags
//  Revision    : 1.0  initial release
// ============================================================================
module ts_merge_fifo #(
   parameter int WIDTH = 104,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_empty,
   output logic             o_full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_cnt;

   logic w_wr;
   logic w_rd;

   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_rdata = r_mem[r_rptr];

   // A full FIFO can still take a write when its head leaves this cycle.
   assign w_wr = i_push & (~o_full | i_pop);
   assign w_rd = i_pop & ~o_empty;

   // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
   // naturally modulo DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage needs no reset: contents are only visible through the counters.
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= i_wdata;
   end

endmodule : ts_merge_fifo
`default_nettype wire

// File: rtl/ts_merge_rr.sv
`default_nettype none
// ============================================================================
//  Module      : ts_merge_rr
//  Description : Merges NUM_PORTS timestamp streams into one output stream.
//                Each port has a FIFO_DEPTH buffer (no input backpressure;
//                inputs arriving at a full buffer are dropped and flagged).
//                A single output register is refilled round-robin starting
//                after the last granted port.
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                i_ts_valid   - per-port input strobe
//                i_ts_data    - packed per-port timestamps
//                i_ts_fp      - packed per-port fingerprints
//                o_ts_valid   - merged output valid
//                i_ts_ready   - downstream ready
//                o_ts_data    - merged timestamp
//                o_ts_fp      - merged fingerprint
//                o_ts_port    - source port of current output
//                o_fifo_full  - per-port buffer full flags
//                o_drop       - per-port one-cycle drop pulse
//                o_ovf_cnt    - per-port saturating drop counters
//                               (only with TS_MERGE_OVF_CNT_EN defined)
//  Revision    : 1.0  initial release
// ============================================================================
module ts_merge_rr
   import ts_merge_pkg::*;
#(
   parameter int DATA_WIDTH = 96,
   parameter int FP_WIDTH   = 8,
   parameter int NUM_PORTS  = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_PORTS-1:0]             i_ts_valid,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i_ts_data,
   input  logic [NUM_PORTS*FP_WIDTH-1:0]    i_ts_fp,
   output logic                             o_ts_valid,
   input  logic                             i_ts_ready,
   output logic [DATA_WIDTH-1:0]            o_ts_data,
   output logic [FP_WIDTH-1:0]              o_ts_fp,
   output logic [$clog2(NUM_PORTS)-1:0]     o_ts_port,
   output logic [NUM_PORTS-1:0]             o_fifo_full,
   output logic [NUM_PORTS-1:0]             o_drop
`ifdef TS_MERGE_OVF_CNT_EN
   ,
   output logic [NUM_PORTS*C_OVF_CNT_W-1:0] o_ovf_cnt
`endif
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int EW = DATA_WIDTH + FP_WIDTH;

   logic [NUM_PORTS-1:0][EW-1:0] w_wdata;
   logic [NUM_PORTS-1:0][EW-1:0] w_rdata;
   logic [NUM_PORTS-1:0]         w_empty;
   logic [NUM_PORTS-1:0]         w_full;
   logic [NUM_PORTS-1:0]         w_pop;
   logic [NUM_PORTS-1:0]         w_drop_nxt;
   logic                         w_any;
   logic [PW-1:0]                w_grant;
   logic                         w_load;

   logic                         r_valid;
   logic [DATA_WIDTH-1:0]        r_data;
   logic [FP_WIDTH-1:0]          r_fp;
   logic [PW-1:0]                r_port;
   logic [PW-1:0]                r_last;
   logic [NUM_PORTS-1:0]         r_drop;

   // ------------------------------------------------------------------------
   // Per-port buffers
   // ------------------------------------------------------------------------
   generate
      for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
         assign w_wdata[g] = {i_ts_data[g*DATA_WIDTH +: DATA_WIDTH],
                              i_ts_fp[g*FP_WIDTH +: FP_WIDTH]};

         ts_merge_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (i_ts_valid[g]),
            .i_wdata (w_wdata[g]),
            .i_pop   (w_pop[g]),
            .o_rdata (w_rdata[g]),
            .o_empty (w_empty[g]),
            .o_full  (w_full[g])
         );

         // Dropped only if the head is not leaving in the same cycle.
         assign w_drop_nxt[g] = i_ts_valid[g] & w_full[g] & ~w_pop[g];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Round-robin search: first non-empty port at (r_last + 1 + i) mod N.
   // The sum is at most 2N-1, which fits PW+1 bits, so one conditional
   // subtraction implements the modulo for any N.
   // ------------------------------------------------------------------------
   always_comb begin
      logic [PW:0] v_sum;
      logic [PW-1:0] v_idx;
      w_any   = 1'b0;
      w_grant = '0;
      v_sum   = '0;
      v_idx   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         v_sum = {1'b0, r_last} + (PW+1)'(i) + (PW+1)'(1);
         if (v_sum >= (PW+1)'(NUM_PORTS)) v_sum = v_sum - (PW+1)'(NUM_PORTS);
         v_idx = v_sum[PW-1:0];
         if (!w_any && !w_empty[v_idx]) begin
            w_any   = 1'b1;
            w_grant = v_idx;
         end
      end
   end

   // Output register refills when empty or when its content is transferring.
   assign w_load = w_any & (~r_valid | i_ts_ready);

   always_comb begin
      w_pop = '0;
      if (w_load) w_pop[w_grant] = 1'b1;
   end

   // ------------------------------------------------------------------------
   // Output register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_fp    <= '0;
         r_port  <= '0;
         r_last  <= PW'(NUM_PORTS - 1);
         r_drop  <= '0;
      end else begin
         r_drop <= w_drop_nxt;
         if (w_load) begin
            r_valid <= 1'b1;
            r_data  <= w_rdata[w_grant][EW-1:FP_WIDTH];
            r_fp    <= w_rdata[w_grant][FP_WIDTH-1:0];
            r_port  <= w_grant;
            r_last  <= w_grant;
         end else if (i_ts_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_ts_valid  = r_valid;
   assign o_ts_data   = r_data;
   assign o_ts_fp     = r_fp;
   assign o_ts_port   = r_port;
   assign o_fifo_full = w_full;
   assign o_drop      = r_drop;

`ifdef TS_MERGE_OVF_CNT_EN
   // ------------------------------------------------------------------------
   // Saturating per-port drop counters, updated with the drop pulse.
   // ------------------------------------------------------------------------
   generate
      for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ovf
         logic [C_OVF_CNT_W-1:0] r_ovf;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)             r_ovf <= '0;
            else if (w_drop_nxt[g]) r_ovf <= ovf_sat_inc(r_ovf);
         end
         assign o_ovf_cnt[g*C_OVF_CNT_W +: C_OVF_CNT_W] = r_ovf;
      end
   endgenerate
`endif

endmodule : ts_merge_rr
`default_nettype wire
